// File: rtl/hazard_detection_unit.sv
// Hazard detection for the RV32IM 5-stage pipeline: scoreboard of EX/MA/WB destinations,
// operand-forwarding selects, load-use stall and multi-cycle divider hold controls.
module hazard_detection_unit #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       id_valid,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] id_rd_addr,
    input  logic       id_reg_write,
    input  logic       id_mem_read,
    input  logic       id_is_div,
    input  logic       flush,
    output logic [1:0] forward_rs1,
    output logic [1:0] forward_rs2,
    output logic       stall_pc,
    output logic       stall_if_id,
    output logic       bubble_ex,
    output logic       hold_ex,
    output logic       bubble_ma
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       is_div;
    } sb_entry_t;

    typedef enum logic [1:0] {
        ADV_NORMAL,
        ADV_HOLD,
        ADV_FLUSH,
        ADV_STALL
    } adv_t;

    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

    sb_entry_t  r_ex, r_ma, r_wb;
    logic [7:0] r_div_cnt;

    sb_entry_t  w_id_entry;
    logic       w_div_busy;
    logic       w_load_use;
    adv_t       w_adv;

    function automatic logic is_writer(input sb_entry_t e);
        return e.valid && e.reg_write && (e.rd != 5'd0);
    endfunction

    // allow_load: WB results are final even for loads; busy: divider still computing
    function automatic logic can_forward(input sb_entry_t e, input logic [4:0] src,
                                         input logic allow_load, input logic busy);
        return is_writer(e) && (e.rd == src) && (allow_load || !e.mem_read)
               && !(e.is_div && busy);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic used);
        logic [1:0] sel;
        sel = 2'b00;
        if (used && (src != 5'd0)) begin
            if (can_forward(r_ex, src, 1'b0, w_div_busy))
                sel = 2'b01;
            else if (can_forward(r_ma, src, 1'b0, 1'b0))
                sel = 2'b10;
            else if (can_forward(r_wb, src, 1'b1, 1'b0))
                sel = 2'b11;
        end
        return sel;
    endfunction

    function automatic logic hits_load(input logic [4:0] src, input logic used);
        return used && (src != 5'd0) &&
               ((is_writer(r_ex) && r_ex.mem_read && (r_ex.rd == src)) ||
                (is_writer(r_ma) && r_ma.mem_read && (r_ma.rd == src)));
    endfunction

    always_comb begin
        w_id_entry = '{valid:     id_valid,
                       rd:        id_rd_addr,
                       reg_write: id_reg_write,
                       mem_read:  id_mem_read,
                       is_div:    id_is_div};
        w_div_busy = (r_div_cnt != 8'd0);
        w_load_use = id_valid &&
                     (hits_load(id_rs1_addr, id_rs1_used) || hits_load(id_rs2_addr, id_rs2_used));

        if (w_div_busy)
            w_adv = ADV_HOLD;
        else if (flush)
            w_adv = ADV_FLUSH;
        else if (w_load_use)
            w_adv = ADV_STALL;
        else
            w_adv = ADV_NORMAL;
    end

    always_comb begin
        forward_rs1 = fwd_sel(id_rs1_addr, id_rs1_used);
        forward_rs2 = fwd_sel(id_rs2_addr, id_rs2_used);
        stall_pc    = 1'b0;
        stall_if_id = 1'b0;
        bubble_ex   = 1'b0;
        hold_ex     = 1'b0;
        bubble_ma   = 1'b0;
        case (w_adv)
            ADV_HOLD: begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                hold_ex     = 1'b1;
                bubble_ma   = 1'b1;
            end
            ADV_STALL: begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                bubble_ex   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ex      <= '0;
            r_ma      <= '0;
            r_wb      <= '0;
            r_div_cnt <= '0;
        end else begin
            case (w_adv)
                ADV_HOLD: begin
                    r_ma      <= '0;
                    r_wb      <= r_ma;
                    r_div_cnt <= r_div_cnt - 8'd1;
                end
                ADV_FLUSH, ADV_STALL: begin
                    r_ex <= '0;
                    r_ma <= r_ex;
                    r_wb <= r_ma;
                end
                default: begin
                    r_ex <= w_id_entry;
                    r_ma <= r_ex;
                    r_wb <= r_ma;
                    if (id_valid && id_is_div)
                        r_div_cnt <= DIV_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed walk through the pipeline hazard scenarios, then randomized traffic
// checked against a stage-list reference model of the hazard rules.
module tb_hazard_detection_unit;

    localparam int DIVC = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       id_valid;
    logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic       id_rs1_used, id_rs2_used, id_reg_write, id_mem_read, id_is_div;
    logic       flush;
    logic [1:0] forward_rs1, forward_rs2;
    logic       stall_pc, stall_if_id, bubble_ex, hold_ex, bubble_ma;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_detection_unit #(.DIV_CYCLES(DIVC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .id_valid    (id_valid),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd_addr  (id_rd_addr),
        .id_reg_write(id_reg_write),
        .id_mem_read (id_mem_read),
        .id_is_div   (id_is_div),
        .flush       (flush),
        .forward_rs1 (forward_rs1),
        .forward_rs2 (forward_rs2),
        .stall_pc    (stall_pc),
        .stall_if_id (stall_if_id),
        .bubble_ex   (bubble_ex),
        .hold_ex     (hold_ex),
        .bubble_ma   (bubble_ma)
    );

    always #5 clk = ~clk;

    // Reference model: stage list 0=EX, 1=MA, 2=WB, plus remaining divider busy cycles
    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit mr;
        bit dv;
    } ent_t;

    ent_t pipe[3];
    int   div_left = 0;

    function automatic ent_t empty_ent();
        ent_t e;
        e.v = 0; e.rd = 0; e.rw = 0; e.mr = 0; e.dv = 0;
        return e;
    endfunction

    function automatic bit m_writes(input ent_t e, input int r);
        return e.v && e.rw && e.rd != 0 && e.rd == r;
    endfunction

    function automatic logic [1:0] m_fwd(input int src, input bit used);
        if (!used || src == 0) return 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (!m_writes(pipe[i], src)) continue;
            if (i < 2 && pipe[i].mr) continue;
            if (i == 0 && pipe[i].dv && div_left > 0) continue;
            return 2'(i + 1);
        end
        return 2'd0;
    endfunction

    function automatic bit m_load_use();
        bit hit;
        hit = 0;
        if (!id_valid) return 0;
        for (int i = 0; i < 2; i++) begin
            if (pipe[i].mr && id_rs1_used && id_rs1_addr != 0 && m_writes(pipe[i], int'(id_rs1_addr))) hit = 1;
            if (pipe[i].mr && id_rs2_used && id_rs2_addr != 0 && m_writes(pipe[i], int'(id_rs2_addr))) hit = 1;
        end
        return hit;
    endfunction

    // {stall_pc, stall_if_id, bubble_ex, hold_ex, bubble_ma}
    function automatic logic [4:0] m_ctl();
        if (div_left > 0) return 5'b11011;
        if (flush)        return 5'b00000;
        if (m_load_use()) return 5'b11100;
        return 5'b00000;
    endfunction

    task automatic model_step();
        ent_t id_e;
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) pipe[i] = empty_ent();
            div_left = 0;
        end else if (div_left > 0) begin
            pipe[2] = pipe[1];
            pipe[1] = empty_ent();
            div_left--;
        end else if (flush || m_load_use()) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = empty_ent();
        end else begin
            id_e.v = id_valid; id_e.rd = int'(id_rd_addr); id_e.rw = id_reg_write;
            id_e.mr = id_mem_read; id_e.dv = id_is_div;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = id_e;
            if (id_valid && id_is_div) div_left = DIVC - 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cmp(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] ctl_obs();
        return {stall_pc, stall_if_id, bubble_ex, hold_ex, bubble_ma};
    endfunction

    task automatic exp_all(input string tag, input logic [1:0] f1, input logic [1:0] f2,
                           input logic [4:0] ctl);
        #3;
        cmp({tag, ".fwd1"}, {3'b0, forward_rs1}, {3'b0, f1});
        cmp({tag, ".fwd2"}, {3'b0, forward_rs2}, {3'b0, f2});
        cmp({tag, ".ctl"}, ctl_obs(), ctl);
    endtask

    task automatic exp_ctl(input string tag, input logic [4:0] ctl);
        #3;
        cmp({tag, ".ctl"}, ctl_obs(), ctl);
    endtask

    task automatic chk_model(input string tag);
        #3;
        cmp({tag, ".fwd1"}, {3'b0, forward_rs1}, {3'b0, m_fwd(int'(id_rs1_addr), id_rs1_used)});
        cmp({tag, ".fwd2"}, {3'b0, forward_rs2}, {3'b0, m_fwd(int'(id_rs2_addr), id_rs2_used)});
        cmp({tag, ".ctl"}, ctl_obs(), m_ctl());
    endtask

    task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, input bit rw, input bit mr, input bit dv);
        id_valid = v;
        id_rs1_addr = 5'(rs1); id_rs1_used = u1;
        id_rs2_addr = 5'(rs2); id_rs2_used = u2;
        id_rd_addr = 5'(rd); id_reg_write = rw; id_mem_read = mr; id_is_div = dv;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) pipe[i] = empty_ent();
        reset_n = 1'b0;
        flush   = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_model("reset_hold");
        exp_all("reset", 2'd0, 2'd0, 5'b00000);
        tick();
        reset_n = 1'b1;

        // ADD x5 ; SUB x6,x5,x5 ; ADD x11,x5,x0 ; SW x6 -> (x5)
        set_id(1, 1, 1, 2, 1, 5, 1, 0, 0);  exp_all("add_x5", 2'd0, 2'd0, 5'b00000); tick();
        set_id(1, 5, 1, 5, 1, 6, 1, 0, 0);  exp_all("fwd_ex", 2'd1, 2'd1, 5'b00000); tick();
        set_id(1, 5, 1, 0, 1, 11, 1, 0, 0); exp_all("fwd_ma", 2'd2, 2'd0, 5'b00000); tick();
        set_id(1, 5, 1, 6, 1, 5, 0, 0, 0);  exp_all("fwd_wb", 2'd3, 2'd2, 5'b00000); tick();

        // LW x7 ; ADD x8,x7,x1 -> two stall cycles then WB forward
        set_id(1, 2, 1, 0, 0, 7, 1, 1, 0);  exp_all("lw_x7", 2'd0, 2'd0, 5'b00000); tick();
        set_id(1, 7, 1, 1, 1, 8, 1, 0, 0);  exp_all("lu_stall1", 2'd0, 2'd0, 5'b11100); tick();
        exp_all("lu_stall2", 2'd0, 2'd0, 5'b11100); tick();
        exp_all("lu_release", 2'd3, 2'd0, 5'b00000); tick();

        // Writer to x0, then non-writer to x12, then readers
        set_id(1, 1, 1, 0, 0, 0, 1, 0, 0);  exp_all("wr_x0", 2'd0, 2'd0, 5'b00000); tick();
        set_id(1, 0, 1, 0, 1, 12, 0, 0, 0); exp_all("rd_x0", 2'd0, 2'd0, 5'b00000); tick();
        set_id(1, 12, 1, 0, 1, 0, 0, 0, 0); exp_all("rd_nowr", 2'd0, 2'd0, 5'b00000); tick();

        // Flush while a load-use consumer sits in ID
        set_id(1, 2, 1, 0, 0, 7, 1, 1, 0);  exp_all("lw_x7b", 2'd0, 2'd0, 5'b00000); tick();
        set_id(1, 7, 1, 0, 0, 13, 1, 0, 0);
        flush = 1'b1;                        exp_all("flush_lu", 2'd0, 2'd0, 5'b00000); tick();
        flush = 1'b0;
        set_id(1, 13, 1, 0, 0, 0, 0, 0, 0); exp_all("post_flush", 2'd0, 2'd0, 5'b00000); tick();

        // DIV x9 ; ADD x10,x9,x0 -> 3 hold cycles then EX forward
        set_id(1, 3, 1, 4, 1, 9, 1, 0, 1);  exp_all("div_x9", 2'd0, 2'd0, 5'b00000); tick();
        set_id(1, 9, 1, 0, 1, 10, 1, 0, 0);
        exp_ctl("div_hold1", 5'b11011); tick();
        exp_ctl("div_hold2", 5'b11011); tick();
        exp_ctl("div_hold3", 5'b11011); tick();
        exp_all("div_done", 2'd1, 2'd0, 5'b00000); tick();

        // Reset in the middle of a divider hold
        set_id(1, 3, 1, 4, 1, 14, 1, 0, 1); exp_all("div_x14", 2'd0, 2'd0, 5'b00000); tick();
        set_id(1, 14, 1, 0, 0, 15, 1, 0, 0);
        exp_ctl("div14_hold1", 5'b11011); tick();
        reset_n = 1'b0;
        exp_ctl("div14_hold_rst", 5'b11011); tick();
        reset_n = 1'b1;
        exp_all("after_rst", 2'd0, 2'd0, 5'b00000);
        chk_model("after_rst_m");
        tick();

        // Randomized traffic over a small register range to provoke hazards
        for (int c = 0; c < 400; c++) begin
            set_id($urandom_range(0, 3) != 0,
                   int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                   int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                   int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0);
            flush   = ($urandom_range(0, 9) == 0);
            reset_n = ($urandom_range(0, 39) != 0);
            chk_model("rand");
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Generates the forwarding select codes and pipeline stall/bubble controls for the RV32IM 5-stage pipeline. It sits beside the ID stage. It tracks the destination register, write-enable, load and divide attributes of the instructions in EX, MA and WB in an internal scoreboard. From that scoreboard it drives `forward_rs1`/`forward_rs2` to the operand-forwarding mux, and it drives stall, hold and bubble controls to the PC, IF/ID, ID/EX and EX/MA registers, covering load-use hazards and the multi-cycle divider.

## Interface
Parameters:
- `DIV_CYCLES`, default 32: EX occupancy of DIV/DIVU/REM/REMU in cycles; legal range 1..255.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `id_valid` input 1: ID holds a real instruction.
- `id_rs1_addr`, `id_rs2_addr` input 5: ID source registers.
- `id_rs1_used`, `id_rs2_used` input 1: the instruction reads rs1 / rs2.
- `id_rd_addr` input 5: ID destination register.
- `id_reg_write` input 1: the ID instruction writes rd.
- `id_mem_read` input 1: the ID instruction is a load.
- `id_is_div` input 1: the ID instruction is a divide or remainder.
- `flush` input 1: a taken branch or jump is resolved in EX this cycle.
- `forward_rs1`, `forward_rs2` output 2: 00 selects the register file, 01 EX, 10 MA, 11 WB.
- `stall_pc` output 1: hold the PC.
- `stall_if_id` output 1: hold the IF/ID register.
- `bubble_ex` output 1: load a NOP into ID/EX.
- `hold_ex` output 1: hold the ID/EX register and the EX-stage state.
- `bubble_ma` output 1: load a NOP into EX/MA.

## Operation
- Scoreboard holds three entries, `ex`, `ma` and `wb`. Each entry is {valid, rd, reg_write, mem_read, is_div}.
- An entry counts as a *writer* only when valid=1, reg_write=1 and rd≠0.
- Normal advance: `wb`←`ma`, `ma`←`ex`, `ex`←ID fields, with valid=id_valid.
- Forward select for each used source, in priority order:
  - `ex` writer with matching rd and not a load: 01.
  - otherwise `ma` writer with matching rd and not a load: 10.
  - otherwise `wb` writer with matching rd: 11.
  - otherwise 00.
- An unused source or x0 always gets 00.
- Load-use stall:
  - Condition: a used source matches a writer in `ex` or `ma` whose mem_read=1.
  - Response: `stall_pc`=`stall_if_id`=`bubble_ex`=1.
  - On the next edge `ex` receives an invalid entry and the others advance.
  - A load directly followed by its consumer stalls 2 cycles, then forwards 11.
- Divider hold:
  - When a valid `is_div` instruction advances into `ex`, `div_cnt` (8 bits) loads DIV_CYCLES−1.
  - While `div_cnt`≠0: `hold_ex`=`stall_pc`=`stall_if_id`=`bubble_ma`=1, and `bubble_ex`=0.
  - During the hold, `ex` is frozen, `ma` receives an invalid entry, `wb`←`ma`, and `div_cnt` decrements.
  - A divide therefore occupies EX for DIV_CYCLES cycles. DIV_CYCLES=1 produces no hold.
  - The divide result is forwarded as 01 only once `div_cnt`=0.
- Priority, highest first: reset, then divider hold, then flush, then load-use stall.
- Flush:
  - Next `ex` is invalid and the ID instruction is squashed.
  - The load-use stall is suppressed in the flush cycle.
  - `stall_pc` and `stall_if_id` are 0.
  - `ma` and `wb` advance normally.
- Stall and hold outputs are all 0 whenever no condition is active.

## Timing
- Forward and stall outputs are combinational from the scoreboard registers and the ID inputs of the same cycle. No flop sits between a change on an ID input and the outputs.
- Scoreboard and `div_cnt` update only on the `clk` rising edge.
- Reset (`reset_n`=0 at an edge) clears all entries to invalid and sets `div_cnt`=0.
- Reset values:
  - Next cycle: `forward_rs1`/`forward_rs2`=00 and all stall, hold and bubble outputs 0.
  - While `reset_n` is held low, the outputs still decode combinationally, against an empty scoreboard.
- Reset during a divider hold aborts the hold at that edge.
- Reset during a load-use stall drops the stall at that edge.
- `id_valid`=0 never causes a stall.
- A matching WB writer needs no stall; it forwards 11 even when a register file write-through exists.

## Test plan
- ADD x5 then SUB x6,x5,x5 back-to-back → in the SUB's ID cycle `forward_rs1`=`forward_rs2`=01, no stall. One instruction later the select is 10; two later it is 11.
- LW x7 then ADD x8,x7,x1 → 2 cycles of `stall_pc`=`stall_if_id`=`bubble_ex`=1, then `forward_rs1`=11 and `forward_rs2`=00.
- DIV x9 with DIV_CYCLES=4, followed by ADD x10,x9,x0 → `hold_ex`=`bubble_ma`=1 for exactly 3 cycles, then `forward_rs1`=01 in the following cycle.
- Writer with rd=x0, or reg_write=0, followed by a reader of x0 or the same rd → forward=00, no stall.
- LW x7 in `ex` with consumer in ID and `flush`=1 → no stall that cycle, and the next `ex` is invalid.
- `reset_n` low for one edge mid-DIV hold (`div_cnt`=2) → next cycle all outputs 0, the scoreboard is empty and forward=00.
